// File: rtl/mfp_timer_ctrl.sv
// Register front-end and bus scheduler for the four MFP68901 timers (A-D).
// Optional TIPR/TIMR interrupt pending/mask registers are enabled by defining MFP_TIMER_IRQ_EN.
module mfp_timer_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CS,
  input  logic        DS,
  input  logic        RW,
  input  logic [4:0]  ADDR,
  input  logic [7:0]  DIN,
  output logic [7:0]  DOUT,
  output logic        DTACK,
  output logic [3:0]  TMR_DAT_WE,
  output logic [7:0]  TMR_DAT_I,
  output logic [3:0]  TMR_CTRL_WE,
  output logic [19:0] TMR_CTRL_I,
  input  logic [31:0] TMR_DAT_O,
  input  logic [15:0] TMR_CTRL_O,
  input  logic [3:0]  TMR_PULSE,
  output logic [3:0]  IRQ,
  output logic [1:0]  STATE_DBG
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;

  localparam logic [4:0] A_TACR  = 5'h0C;
  localparam logic [4:0] A_TBCR  = 5'h0D;
  localparam logic [4:0] A_TCDCR = 5'h0E;
  localparam logic [4:0] A_TADR  = 5'h0F;
  localparam logic [4:0] A_TBDR  = 5'h10;
  localparam logic [4:0] A_TCDR  = 5'h11;
  localparam logic [4:0] A_TDDR  = 5'h12;
  localparam logic [4:0] A_TIPR  = 5'h18;
  localparam logic [4:0] A_TIMR  = 5'h19;

  logic [1:0]  state_q, state_d;
  logic        ds_last_q;
  logic        dtack_q, dtack_d;
  logic [7:0]  dout_q, dout_d;
  logic [4:0]  addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [3:0]  dat_we_q, dat_we_d;
  logic [3:0]  ctrl_we_q, ctrl_we_d;
  logic [7:0]  dat_i_q, dat_i_d;
  logic [19:0] ctrl_i_q, ctrl_i_d;
  logic        start;
  logic        wr_go;
  logic [7:0]  rd_data;
  logic [3:0]  tipr_q, timr_q;

  // Only a rising DS while idle starts an access; DS_last resets high so a
  // strobe already asserted across reset is not mistaken for a new cycle.
  assign start = CS & DS & ~ds_last_q;
  assign wr_go = (state_q == S_IDLE) & start & ~RW;

  always_comb begin
    rd_data = 8'h00;
    case (addr_q)
      A_TACR:  rd_data = {4'b0000, TMR_CTRL_O[3:0]};
      A_TBCR:  rd_data = {4'b0000, TMR_CTRL_O[7:4]};
      A_TCDCR: rd_data = {1'b0, TMR_CTRL_O[10:8], 1'b0, TMR_CTRL_O[14:12]};
      A_TADR:  rd_data = TMR_DAT_O[7:0];
      A_TBDR:  rd_data = TMR_DAT_O[15:8];
      A_TCDR:  rd_data = TMR_DAT_O[23:16];
      A_TDDR:  rd_data = TMR_DAT_O[31:24];
`ifdef MFP_TIMER_IRQ_EN
      A_TIPR:  rd_data = {4'b0000, tipr_q};
      A_TIMR:  rd_data = {4'b0000, timr_q};
`endif
      default: rd_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    dtack_d   = dtack_q;
    dout_d    = dout_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    dat_we_d  = 4'b0000;
    ctrl_we_d = 4'b0000;
    dat_i_d   = dat_i_q;
    ctrl_i_d  = ctrl_i_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCESS;
          addr_d  = ADDR;
          rw_d    = RW;
          if (!RW) begin
            case (ADDR)
              A_TACR: begin
                ctrl_we_d      = 4'b0001;
                ctrl_i_d[4:0]  = DIN[4:0];
              end
              A_TBCR: begin
                ctrl_we_d      = 4'b0010;
                ctrl_i_d[9:5]  = DIN[4:0];
              end
              // TCDCR carries both C and D prescalers, so both timers load together.
              A_TCDCR: begin
                ctrl_we_d       = 4'b1100;
                ctrl_i_d[14:10] = {2'b00, DIN[6:4]};
                ctrl_i_d[19:15] = {2'b00, DIN[2:0]};
              end
              A_TADR: begin
                dat_we_d = 4'b0001;
                dat_i_d  = DIN;
              end
              A_TBDR: begin
                dat_we_d = 4'b0010;
                dat_i_d  = DIN;
              end
              A_TCDR: begin
                dat_we_d = 4'b0100;
                dat_i_d  = DIN;
              end
              A_TDDR: begin
                dat_we_d = 4'b1000;
                dat_i_d  = DIN;
              end
              default: ;
            endcase
          end
        end
      end
      S_ACCESS: begin
        state_d = S_ACK;
        dtack_d = 1'b1;
        if (rw_q) dout_d = rd_data;
      end
      S_ACK: begin
        if (!DS) begin
          state_d = S_IDLE;
          dtack_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      ds_last_q <= 1'b1;
      dtack_q   <= 1'b0;
      dout_q    <= 8'h00;
      addr_q    <= 5'h00;
      rw_q      <= 1'b0;
      dat_we_q  <= 4'b0000;
      ctrl_we_q <= 4'b0000;
      dat_i_q   <= 8'h00;
      ctrl_i_q  <= 20'h00000;
    end else begin
      state_q   <= state_d;
      ds_last_q <= DS;
      dtack_q   <= dtack_d;
      dout_q    <= dout_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      dat_we_q  <= dat_we_d;
      ctrl_we_q <= ctrl_we_d;
      dat_i_q   <= dat_i_d;
      ctrl_i_q  <= ctrl_i_d;
    end
  end

`ifdef MFP_TIMER_IRQ_EN
  logic [3:0] tipr_d, timr_d;
  logic [3:0] irq_q;

  // Writing TIPR can only clear bits; a timeout pulse in the same cycle wins.
  always_comb begin
    tipr_d = tipr_q;
    timr_d = timr_q;
    if (wr_go && (ADDR == A_TIPR)) tipr_d = tipr_q & DIN[3:0];
    if (wr_go && (ADDR == A_TIMR)) timr_d = DIN[3:0];
    tipr_d = tipr_d | TMR_PULSE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tipr_q <= 4'b0000;
      timr_q <= 4'b0000;
      irq_q  <= 4'b0000;
    end else begin
      tipr_q <= tipr_d;
      timr_q <= timr_d;
      irq_q  <= tipr_q & timr_q;
    end
  end

  assign IRQ = irq_q;
`else
  assign tipr_q = 4'b0000;
  assign timr_q = 4'b0000;
  assign IRQ    = 4'b0000;
`endif

  logic unused_ok;
  assign unused_ok = ^{TMR_PULSE, TMR_CTRL_O[11], TMR_CTRL_O[15], tipr_q, timr_q, wr_go};

  assign DOUT        = dout_q;
  assign DTACK       = dtack_q;
  assign TMR_DAT_WE  = dat_we_q;
  assign TMR_DAT_I   = dat_i_q;
  assign TMR_CTRL_WE = ctrl_we_q;
  assign TMR_CTRL_I  = ctrl_i_q;
  assign STATE_DBG   = state_q;

endmodule

// File: tb/tb_mfp_timer_ctrl.sv
// Randomized scoreboard bench for mfp_timer_ctrl; the register model is kept as plain variables.
// Build with MFP_TIMER_IRQ_EN defined to cover the TIPR/TIMR interrupt registers.
`timescale 1ns/1ps
module tb_mfp_timer_ctrl;

  logic        CLK = 1'b0;
  logic        RST, CS, DS, RW;
  logic [4:0]  ADDR;
  logic [7:0]  DIN;
  logic [7:0]  DOUT;
  logic        DTACK;
  logic [3:0]  TMR_DAT_WE, TMR_CTRL_WE;
  logic [7:0]  TMR_DAT_I;
  logic [19:0] TMR_CTRL_I;
  logic [31:0] TMR_DAT_O;
  logic [15:0] TMR_CTRL_O;
  logic [3:0]  TMR_PULSE;
  logic [3:0]  IRQ;
  logic [1:0]  STATE_DBG;

  mfp_timer_ctrl dut (
    .CLK(CLK), .RST(RST), .CS(CS), .DS(DS), .RW(RW), .ADDR(ADDR), .DIN(DIN),
    .DOUT(DOUT), .DTACK(DTACK), .TMR_DAT_WE(TMR_DAT_WE), .TMR_DAT_I(TMR_DAT_I),
    .TMR_CTRL_WE(TMR_CTRL_WE), .TMR_CTRL_I(TMR_CTRL_I), .TMR_DAT_O(TMR_DAT_O),
    .TMR_CTRL_O(TMR_CTRL_O), .TMR_PULSE(TMR_PULSE), .IRQ(IRQ), .STATE_DBG(STATE_DBG)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Expected entry: {dout[8], dat_we[4], ctrl_we[4], dat_i[8], ctrl_i[20]}
  localparam int W = 44;
  logic [W-1:0] exp_q[$];

  int n_pass = 0;
  int n_total = 0;
  int we_cycles = 0;
  int exp_we_cycles = 0;

  // reference model state
  logic [7:0]  m_dout;
  logic [7:0]  m_dat_i;
  logic [19:0] m_ctrl_i;
  logic [3:0]  m_tipr;
  logic [3:0]  m_timr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_dout = 8'h00; m_dat_i = 8'h00; m_ctrl_i = 20'h0; m_tipr = 4'h0; m_timr = 4'h0;
  endtask

  // One bus access as a register file would see it; pulse is what the timers raise on the start edge.
  task automatic model_access(input logic rw, input logic [4:0] addr, input logic [7:0] din,
                              input logic [3:0] pulse);
    logic [3:0] dwe, cwe;
    dwe = 4'h0; cwe = 4'h0;
`ifdef MFP_TIMER_IRQ_EN
    if (!rw && addr == 5'h18) m_tipr = (m_tipr & din[3:0]) | pulse;
    else m_tipr = m_tipr | pulse;
    if (!rw && addr == 5'h19) m_timr = din[3:0];
`endif
    if (!rw) begin
      case (addr)
        5'h0C: begin cwe = 4'b0001; m_ctrl_i[4:0] = din[4:0]; end
        5'h0D: begin cwe = 4'b0010; m_ctrl_i[9:5] = din[4:0]; end
        5'h0E: begin
          cwe = 4'b1100;
          m_ctrl_i[14:10] = {2'b00, din[6:4]};
          m_ctrl_i[19:15] = {2'b00, din[2:0]};
        end
        5'h0F, 5'h10, 5'h11, 5'h12: begin
          dwe = 4'b0001 << (addr - 5'h0F);
          m_dat_i = din;
        end
        default: ;
      endcase
    end else begin
      case (addr)
        5'h0C: m_dout = {4'h0, TMR_CTRL_O[3:0]};
        5'h0D: m_dout = {4'h0, TMR_CTRL_O[7:4]};
        5'h0E: m_dout = {1'b0, TMR_CTRL_O[10:8], 1'b0, TMR_CTRL_O[14:12]};
        5'h0F: m_dout = TMR_DAT_O[7:0];
        5'h10: m_dout = TMR_DAT_O[15:8];
        5'h11: m_dout = TMR_DAT_O[23:16];
        5'h12: m_dout = TMR_DAT_O[31:24];
`ifdef MFP_TIMER_IRQ_EN
        5'h18: m_dout = {4'h0, m_tipr};
        5'h19: m_dout = {4'h0, m_timr};
`endif
        default: m_dout = 8'h00;
      endcase
    end
    if ((dwe | cwe) != 4'h0) exp_we_cycles++;
    exp_q.push_back({m_dout, dwe, cwe, m_dat_i, m_ctrl_i});
  endtask

  // scoreboard monitor: compares one entry per DTACK rising edge
  logic         prev_dtack = 1'b0;
  logic [7:0]   prev_we = 8'h00;
  logic [W-1:0] e;

  always @(negedge CLK) begin
    if (DTACK === 1'b1 && prev_dtack === 1'b0) begin
      if (exp_q.size() == 0) check("unexpected_dtack", {31'd0, DTACK}, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("dout", {24'd0, DOUT}, {24'd0, e[43:36]});
        check("dat_we_pulse", {28'd0, prev_we[7:4]}, {28'd0, e[35:32]});
        check("ctrl_we_pulse", {28'd0, prev_we[3:0]}, {28'd0, e[31:28]});
        check("dat_i", {24'd0, TMR_DAT_I}, {24'd0, e[27:20]});
        check("ctrl_i", {12'd0, TMR_CTRL_I}, {12'd0, e[19:0]});
        check("we_low_at_ack", {24'd0, TMR_DAT_WE, TMR_CTRL_WE}, 32'd0);
      end
    end
    if ((TMR_DAT_WE | TMR_CTRL_WE) != 4'h0) we_cycles++;
    prev_dtack = DTACK;
    prev_we = {TMR_DAT_WE, TMR_CTRL_WE};
  end

  // driver tasks
  task automatic do_access(input logic rw, input logic [4:0] addr, input logic [7:0] din,
                           input int hold, input logic [3:0] pulse);
    int n;
    model_access(rw, addr, din, pulse);
    @(negedge CLK);
    CS = 1'b1; RW = rw; ADDR = addr; DIN = din; DS = 1'b1; TMR_PULSE = pulse;
    @(negedge CLK);
    // After the start edge the bus may wander; the latched cycle must not change.
    TMR_PULSE = 4'h0; CS = 1'($urandom_range(0, 1)); ADDR = 5'($urandom); DIN = 8'($urandom);
    n = 0;
    while (DTACK !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("dtack_latency", n, 1);
    repeat (hold) @(negedge CLK);
    check("dtack_hold", {31'd0, DTACK}, 32'd1);
    DS = 1'b0; CS = 1'b0;
    @(negedge CLK);
    check("dtack_fall", {31'd0, DTACK}, 32'd0);
    check("irq", {28'd0, IRQ}, {28'd0, m_tipr & m_timr});
  endtask

  task automatic pulse_timers(input logic [3:0] p);
    logic [3:0] irq_before;
    irq_before = m_tipr & m_timr;
    @(negedge CLK);
    TMR_PULSE = p;
`ifdef MFP_TIMER_IRQ_EN
    m_tipr = m_tipr | p;
`endif
    @(negedge CLK);
    TMR_PULSE = 4'h0;
    check("irq_lag", {28'd0, IRQ}, {28'd0, irq_before});
    @(negedge CLK);
    check("irq_after_pulse", {28'd0, IRQ}, {28'd0, m_tipr & m_timr});
  endtask

  initial begin
    RST = 1'b1; CS = 1'b0; DS = 1'b0; RW = 1'b1; ADDR = 5'h0; DIN = 8'h0;
    TMR_DAT_O = 32'h0; TMR_CTRL_O = 16'h0; TMR_PULSE = 4'h0;
    model_reset();
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    check("rst_dout", {24'd0, DOUT}, 32'd0);
    check("rst_dtack", {31'd0, DTACK}, 32'd0);
    check("rst_we", {24'd0, TMR_DAT_WE, TMR_CTRL_WE}, 32'd0);
    check("rst_dat_i", {24'd0, TMR_DAT_I}, 32'd0);
    check("rst_ctrl_i", {12'd0, TMR_CTRL_I}, 32'd0);
    check("rst_irq", {28'd0, IRQ}, 32'd0);
    check("rst_state", {30'd0, STATE_DBG}, 32'd0);

    // directed register-map cases
    do_access(1'b0, 5'h0C, 8'h15, 0, 4'h0);
    do_access(1'b0, 5'h0E, 8'h53, 0, 4'h0);
    TMR_CTRL_O = 16'h3500 | 16'($urandom_range(0, 255));
    do_access(1'b1, 5'h0E, 8'h00, 0, 4'h0);
    check("tcdcr_read", {24'd0, DOUT}, 32'h53);
    TMR_DAT_O = 32'h00007A00 | ($urandom & 32'hFFFF00FF);
    do_access(1'b1, 5'h10, 8'h00, 1, 4'h0);
    check("tbdr_read", {24'd0, DOUT}, 32'h7A);
    do_access(1'b1, 5'h05, 8'h00, 0, 4'h0);
    check("unmapped_read", {24'd0, DOUT}, 32'h00);
    do_access(1'b0, 5'h05, 8'hFF, 0, 4'h0);
    do_access(1'b0, 5'h10, 8'hA5, 10, 4'h0);

    // DS rise without chip select must not start a cycle
    @(negedge CLK);
    CS = 1'b0; DS = 1'b1; RW = 1'b0; ADDR = 5'h0F; DIN = 8'h3C;
    repeat (4) @(negedge CLK);
    check("no_cs_dtack", {31'd0, DTACK}, 32'd0);
    DS = 1'b0;
    @(negedge CLK);

    // interrupt pending / mask registers
    do_access(1'b0, 5'h19, 8'h02, 0, 4'h0);
    pulse_timers(4'b0010);
    do_access(1'b0, 5'h18, 8'hFD, 0, 4'b0010);
    do_access(1'b0, 5'h18, 8'hFD, 0, 4'h0);
    pulse_timers(4'b1111);
    do_access(1'b1, 5'h18, 8'h00, 0, 4'h0);
    do_access(1'b1, 5'h19, 8'h00, 0, 4'h0);

    // randomized traffic
    for (int i = 0; i < 48; i++) begin
      logic [4:0] a;
      logic [3:0] p;
      case ($urandom_range(0, 3))
        0, 1: a = 5'(5'h0C + $urandom_range(0, 6));
        2:    a = $urandom_range(0, 1) ? 5'h18 : 5'h19;
        default: a = 5'($urandom);
      endcase
      p = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      TMR_DAT_O = $urandom;
      TMR_CTRL_O = 16'($urandom);
      do_access(1'($urandom_range(0, 1)), a, 8'($urandom), $urandom_range(0, 2), p);
    end

    // reset in the middle of an acknowledged cycle with DS held high
    model_access(1'b1, 5'h0F, 8'h00, 4'h0);
    @(negedge CLK);
    CS = 1'b1; RW = 1'b1; ADDR = 5'h0F; DS = 1'b1;
    repeat (3) @(negedge CLK);
    check("pre_rst_dtack", {31'd0, DTACK}, 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    check("mid_rst_dtack", {31'd0, DTACK}, 32'd0);
    check("mid_rst_dout", {24'd0, DOUT}, 32'd0);
    check("mid_rst_state", {30'd0, STATE_DBG}, 32'd0);
    RW = 1'b0; ADDR = 5'h0C; DIN = 8'h1F;
    repeat (5) @(negedge CLK);
    check("no_access_after_rst", {31'd0, DTACK}, 32'd0);
    check("ctrl_i_after_rst", {12'd0, TMR_CTRL_I}, 32'd0);
    DS = 1'b0; CS = 1'b0;
    @(negedge CLK);
    do_access(1'b0, 5'h12, 8'h9C, 0, 4'h0);
    do_access(1'b1, 5'h0D, 8'h00, 0, 4'h0);

    repeat (2) @(negedge CLK);
    check("queue_drained", exp_q.size(), 0);
    check("we_pulse_count", we_cycles, exp_we_cycles);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mfp_timer_ctrl.md
# mfp_timer_ctrl

Register front-end and scheduler for the four MFP68901 timers (A–D). It decodes CPU bus cycles to the timer register window and runs a 3-state bus FSM with DTACK handshaking. It drives per-timer data/control write strobes, including the split TCDCR write that updates timers C and D together, and muxes counter and control readback. It sits between the MFP bus interface and four timer instances.

## Interface
Parameters: none.

- CLK  in  1  system clock; all logic on posedge
- RST  in  1  synchronous, active-high reset
- CS  in  1  chip select, active-high
- DS  in  1  data strobe, active-high; an access starts on its rising edge
- RW  in  1  1 = read, 0 = write
- ADDR  in  5  register index
- DIN  in  8  write data
- DOUT  out  8  registered read data
- DTACK  out  1  transfer acknowledge
- TMR_DAT_WE  out  4  per-timer data-register write strobe; bit0 = A … bit3 = D
- TMR_DAT_I  out  8  shared data for TMR_DAT_WE
- TMR_CTRL_WE  out  4  per-timer control write strobe
- TMR_CTRL_I  out  20  5 bits per timer; [4:0] = A … [19:15] = D
- TMR_DAT_O  in  32  timer counter readback; [7:0] = A
- TMR_CTRL_O  in  16  timer control readback; [3:0] = A
- TMR_PULSE  in  4  one-cycle timeout pulse from each timer
- IRQ  out  4  masked pending timer events (see Configuration)

## Operation
- Register map (ADDR): 0x0C TACR, 0x0D TBCR, 0x0E TCDCR, 0x0F TADR, 0x10 TBDR, 0x11 TCDR, 0x12 TDDR. 0x18 TIPR and 0x19 TIMR exist only with the macro.
- TACR/TBCR write: CTRL_WE for A or B; CTRL_I = DIN[4:0]. Bit4 is the output reset.
- TCDCR write: CTRL_WE[2] and CTRL_WE[3] asserted in the same cycle. C gets {2'b0,DIN[6:4]}, D gets {2'b0,DIN[2:0]}. DIN[7] and DIN[3] are ignored.
- TxDR write: DAT_WE for that timer; DAT_I = DIN.
- Reads:
  - TACR/TBCR read {4'b0, CTRL_O}.
  - TCDCR reads {1'b0, C[2:0], 1'b0, D[2:0]}.
  - TxDR reads TMR_DAT_O of that timer.
- Unmapped index with CS: DTACK still issued, read returns 0x00, write has no effect.
- FSM states:
  - IDLE → ACCESS on CS & DS & ~DS_last, where DS_last is DS registered. ADDR, RW and DIN are latched at this transition.
  - ACCESS → ACK unconditionally.
  - ACK → IDLE when DS = 0.
- Strobes are asserted only for write cycles to mapped indices.
- Only one access per DS assertion. CS or ADDR changes after the start edge are ignored.

## Timing
- Start edge k (IDLE, start condition true): registered WE strobes go high for exactly cycle k..k+1.
- Edge k+1: strobes low, DOUT loaded for reads, DTACK ← 1.
- DTACK holds 1 until an edge samples DS = 0; that edge clears DTACK and returns to IDLE.
- Minimum access is 3 edges.
- DOUT holds its value between reads.
- Timer readback is sampled at k+1. The counter snapshot a timer takes on the DS rise is therefore valid at that point.
- Reset values: DOUT 0x00, DTACK 0, all WE 0, TMR_DAT_I 0, TMR_CTRL_I 0, IRQ 0, TIPR 0, TIMR 0, state IDLE.
- Reset while DS is high: no access until DS falls and rises again. DS_last resets to 1.

## Configuration
- MFP_TIMER_IRQ_EN defined:
  - TIPR[3:0]: bit i is set by TMR_PULSE[i]. A write clears bits where DIN = 0 and leaves bits where DIN = 1.
  - A pulse in the same cycle as a clearing write wins (bit stays set).
  - TIMR[3:0] is read/write.
  - IRQ registered = TIPR & TIMR, valid one cycle after the bit changes.
  - Upper nibble reads 0.
- Undefined: no TIPR/TIMR; 0x18/0x19 behave as unmapped; IRQ tied 0; TMR_PULSE ignored.

## Test plan
- Write 0x15 to TACR (CS, DS rise, RW=0) → TMR_CTRL_WE = 0001 for one cycle, TMR_CTRL_I[4:0] = 0x15. DTACK rises the next edge and falls one edge after DS drops.
- Write 0x53 to TCDCR → CTRL_WE = 1100 in the same cycle; CTRL_I[14:10] = 0x05, [19:15] = 0x03. Read TCDCR with C = 5, D = 3 → DOUT = 0x53.
- TMR_DAT_O[15:8] = 0x7A, read TBDR → DOUT = 0x7A at the DTACK edge. Read 0x05 → DOUT = 0x00 with DTACK.
- Hold DS high for 10 cycles → exactly one WE pulse and one access. Assert RST mid-ACK → DTACK = 0 next edge; no new access until DS toggles.
- (IRQ_EN) TIMR = 0x02, pulse TMR_PULSE[1] → IRQ = 0010 one cycle later. Write TIPR = 0xFD together with a new pulse → bit stays set. Write 0xFD alone → IRQ = 0.
- (no IRQ_EN) Pulse all timers → IRQ stays 0000. Read 0x18 → 0x00.
